// File: rtl/usart_fifo.sv
// usart_fifo: full-duplex asynchronous serial transceiver with configurable
// data width, parity, stop bits and bit period, and a receive FIFO.
// Everything runs on the CLK50M domain.
//
// Ports
//   CLK50M        system clock, all logic on posedge
//   RST           synchronous reset, active-high
//   DATA_IN       word to transmit
//   n_WR          active-low transmit write request, sampled every cycle
//   TxD           serial out, idle high
//   Tx_RDY        transmitter idle, a write is accepted this cycle
//   RxD           serial in, asynchronous to CLK50M
//   Rx_RDY        receive FIFO non-empty
//   DATA_OUT      receive FIFO head (first-word fall-through)
//   RD            pop the receive FIFO head
//   rdy_clr       clear the sticky error flags
//   PAR_ERR       sticky parity error
//   FRM_ERR       sticky framing error
//   OVR           sticky overrun (word dropped on a full FIFO)
//   n_INT         active-low interrupt, registered
//   tx_state_dbg  transmit FSM state (IDLE=0 START=1 DATA=2 PAR=3 STOP=4)
//   rx_state_dbg  receive FSM state (IDLE=0 START=1 DATA=2 PAR=3 STOP=4 WAIT_HI=5)
//
// Handshakes
//   Write: n_WR is a level request. A cycle with n_WR=0 and Tx_RDY=1 is the
//   accept; DATA_IN is captured on that edge. Requests while Tx_RDY=0 are
//   ignored, so holding n_WR low sends frames back to back.
//   Read: a cycle with RD=1 and Rx_RDY=1 pops the head; DATA_OUT and Rx_RDY
//   reflect the new head after that edge. RD while empty does nothing.
module usart_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 CLK50M,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] DATA_IN,
  input  logic                 n_WR,
  output logic                 TxD,
  output logic                 Tx_RDY,
  input  logic                 RxD,
  output logic                 Rx_RDY,
  output logic [DATA_BITS-1:0] DATA_OUT,
  input  logic                 RD,
  input  logic                 rdy_clr,
  output logic                 PAR_ERR,
  output logic                 FRM_ERR,
  output logic                 OVR,
  output logic                 n_INT,
  output logic [2:0]           tx_state_dbg,
  output logic [2:0]           rx_state_dbg
);

  // Counter is wide enough for a two-bit-period stop phase.
  localparam int CW = $clog2(2 * CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);
  localparam logic          PAR_EN    = (PARITY != 0);
  // Parity bit = XOR of data for even parity, inverted for odd parity.
  localparam logic          PAR_ODD   = (PARITY == 1);

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_PAR   = 3'd3,
    TX_STOP  = 3'd4
  } tx_state_t;

  tx_state_t            tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_idx;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_par;

  // TxD and Tx_RDY are registered and change on the same edge as the state.
  always_ff @(posedge CLK50M) begin
    if (RST) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shreg <= '0;
      tx_par   <= 1'b0;
      TxD      <= 1'b1;
      Tx_RDY   <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (!n_WR) begin
            tx_shreg <= DATA_IN;
            tx_par   <= (^DATA_IN) ^ PAR_ODD;
            tx_cnt   <= '0;
            TxD      <= 1'b0;
            Tx_RDY   <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            TxD      <= tx_shreg[0];
            tx_shreg <= tx_shreg >> 1;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_idx == IDX_LAST) begin
              if (PAR_EN) begin
                TxD      <= tx_par;
                tx_state <= TX_PAR;
              end else begin
                TxD      <= 1'b1;
                tx_state <= TX_STOP;
              end
            end else begin
              tx_idx   <= tx_idx + 1'b1;
              TxD      <= tx_shreg[0];
              tx_shreg <= tx_shreg >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_PAR: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            TxD      <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == STOP_LAST) begin
            tx_cnt   <= '0;
            Tx_RDY   <= 1'b1;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          TxD      <= 1'b1;
          Tx_RDY   <= 1'b1;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  assign tx_state_dbg = tx_state;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
    RX_PAR     = 3'd3,
    RX_STOP    = 3'd4,
    RX_WAIT_HI = 3'd5
  } rx_state_t;

  rx_state_t            rx_state;
  logic                 rx_meta;
  logic                 rx_sync;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 rx_par_bad;
  logic                 rx_push;   // one-cycle pulse: rx_word is complete
  logic [DATA_BITS-1:0] rx_word;
  logic                 par_ev;
  logic                 frm_ev;

  always_ff @(posedge CLK50M) begin
    if (RST) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_shreg   <= '0;
      rx_par_bad <= 1'b0;
      rx_push    <= 1'b0;
      rx_word    <= '0;
      par_ev     <= 1'b0;
      frm_ev     <= 1'b0;
    end else begin
      rx_meta <= RxD;
      rx_sync <= rx_meta;
      rx_push <= 1'b0;
      par_ev  <= 1'b0;
      frm_ev  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          // Half a bit in: still low means a real start bit, and every
          // later sample lands on a bit centre.
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            if (rx_sync) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_idx     <= '0;
              rx_par_bad <= 1'b0;
              rx_state   <= RX_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shreg <= {rx_sync, rx_shreg[DATA_BITS-1:1]};
            if (rx_idx == IDX_LAST) begin
              rx_state <= PAR_EN ? RX_PAR : RX_STOP;
            end else begin
              rx_idx <= rx_idx + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_PAR: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt     <= '0;
            rx_par_bad <= rx_sync != ((^rx_shreg) ^ PAR_ODD);
            rx_state   <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // The word is delivered even when damaged; the flags say so.
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_push  <= 1'b1;
            rx_word  <= rx_shreg;
            par_ev   <= rx_par_bad;
            frm_ev   <= !rx_sync;
            rx_state <= rx_sync ? RX_IDLE : RX_WAIT_HI;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_WAIT_HI: begin
          // A break holds the line low; wait for it to release before
          // looking for the next start bit.
          if (rx_sync) begin
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_state_dbg = rx_state;

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic [AW:0]          rd_next;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 do_pop;
  logic                 do_push;
  logic                 ovr_ev;
  logic [DATA_BITS-1:0] head_next;

  assign rd_next    = rd_ptr + 1'b1;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop     = RD && !fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push    = rx_push && (!fifo_full || do_pop);
  assign ovr_ev     = rx_push && fifo_full && !do_pop;
  assign Rx_RDY     = !fifo_empty;

  // DATA_OUT is a register holding the head; it only moves when the head
  // changes, so it keeps the last word once the FIFO drains.
  always_comb begin
    head_next = DATA_OUT;
    if (do_pop) begin
      if (rd_next != wr_ptr) begin
        head_next = mem[rd_next[AW-1:0]];
      end else if (do_push) begin
        head_next = rx_word;
      end
    end else if (fifo_empty && do_push) begin
      head_next = rx_word;
    end
  end

  always_ff @(posedge CLK50M) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= rx_word;
    end
  end

  always_ff @(posedge CLK50M) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      DATA_OUT <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_next;
      end
      DATA_OUT <= head_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky flags and interrupt; a new event beats a simultaneous clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK50M) begin
    if (RST) begin
      PAR_ERR <= 1'b0;
      FRM_ERR <= 1'b0;
      OVR     <= 1'b0;
      n_INT   <= 1'b1;
    end else begin
      PAR_ERR <= (PAR_ERR && !rdy_clr) || par_ev;
      FRM_ERR <= (FRM_ERR && !rdy_clr) || frm_ev;
      OVR     <= (OVR && !rdy_clr) || ovr_ev;
      n_INT   <= !(Rx_RDY || PAR_ERR || FRM_ERR || OVR);
    end
  end

endmodule

// File: tb/tb_usart_fifo.sv
// Bench for usart_fifo: 8 data bits, even parity, one stop bit, 8 clocks per
// bit, 4-entry FIFO. Frames reach RxD either through a TxD loopback or from
// a bit-level driver. A queue-based model predicts FIFO contents and flags.
module tb_usart_fifo;

  localparam int CPB   = 8;
  localparam int DB    = 8;
  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          RST;
  logic [DB-1:0] DATA_IN;
  logic          n_WR;
  logic          TxD;
  logic          Tx_RDY;
  logic          RxD;
  logic          Rx_RDY;
  logic [DB-1:0] DATA_OUT;
  logic          RD;
  logic          rdy_clr;
  logic          PAR_ERR;
  logic          FRM_ERR;
  logic          OVR;
  logic          n_INT;
  logic [2:0]    tx_state_dbg;
  logic [2:0]    rx_state_dbg;

  logic loop_en;
  logic rx_drv;
  assign RxD = loop_en ? TxD : rx_drv;

  usart_fifo #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .PARITY      (2),
    .STOP_BITS   (1),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK50M      (clk),
    .RST         (RST),
    .DATA_IN     (DATA_IN),
    .n_WR        (n_WR),
    .TxD         (TxD),
    .Tx_RDY      (Tx_RDY),
    .RxD         (RxD),
    .Rx_RDY      (Rx_RDY),
    .DATA_OUT    (DATA_OUT),
    .RD          (RD),
    .rdy_clr     (rdy_clr),
    .PAR_ERR     (PAR_ERR),
    .FRM_ERR     (FRM_ERR),
    .OVR         (OVR),
    .n_INT       (n_INT),
    .tx_state_dbg(tx_state_dbg),
    .rx_state_dbg(rx_state_dbg)
  );

  // scoreboard / reference model
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DB-1:0] exp_q[$];
  logic          m_par;
  logic          m_frm;
  logic          m_ovr;
  logic [DB-1:0] m_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Even parity: the parity bit makes the count of ones in data+parity even.
  function automatic logic even_bit(input logic [DB-1:0] d);
    int ones = 0;
    for (int i = 0; i < DB; i++) ones += int'(d[i]);
    return (ones % 2) == 1;
  endfunction

  task automatic model_push(input logic [DB-1:0] w, input logic pe, input logic fe);
    if (exp_q.size() == DEPTH) m_ovr = 1'b1;
    else exp_q.push_back(w);
    if (pe) m_par = 1'b1;
    if (fe) m_frm = 1'b1;
    if (exp_q.size() > 0) m_dout = exp_q[0];
  endtask

  task automatic check_state(input string tag);
    logic nonempty;
    nonempty = exp_q.size() > 0;
    chk({tag, ".rx_rdy"}, Rx_RDY, nonempty);
    chk({tag, ".data_out"}, DATA_OUT, m_dout);
    chk({tag, ".par_err"}, PAR_ERR, m_par);
    chk({tag, ".frm_err"}, FRM_ERR, m_frm);
    chk({tag, ".ovr"}, OVR, m_ovr);
    chk({tag, ".n_int"}, n_INT, !(nonempty || m_par || m_frm || m_ovr));
  endtask

  // driver tasks (always entered and left on a negedge)
  task automatic do_rd();
    RD = 1'b1;
    cyc(1);
    RD = 1'b0;
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      if (exp_q.size() > 0) m_dout = exp_q[0];
    end
    cyc(1);
  endtask

  task automatic do_clr();
    rdy_clr = 1'b1;
    cyc(1);
    rdy_clr = 1'b0;
    m_par = 1'b0;
    m_frm = 1'b0;
    m_ovr = 1'b0;
    cyc(1);
  endtask

  task automatic drive_frame(input logic [DB-1:0] d, input logic bad_par, input logic stop_b);
    logic [10:0] bits;
    loop_en = 1'b0;
    bits = {stop_b, even_bit(d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_drv = bits[i];
      cyc(CPB);
    end
    rx_drv = 1'b1;
    cyc(CPB + 4);
  endtask

  task automatic wait_tx_idle(input string tag);
    int k = 0;
    while (!Tx_RDY && k < 400) begin
      cyc(1);
      k++;
    end
    chk({tag, ".tx_done"}, Tx_RDY, 1'b1);
  endtask

  task automatic loop_frame(input logic [DB-1:0] d, input string tag);
    loop_en = 1'b1;
    DATA_IN = d;
    n_WR = 1'b0;
    cyc(1);
    n_WR = 1'b1;
    wait_tx_idle(tag);
    cyc(8);
    model_push(d, 1'b0, 1'b0);
  endtask

  logic [10:0]   bits1;
  logic [10:0]   bits6;
  logic [DB-1:0] d;
  logic          prev_rdy;
  int            accepted;
  int            budget;
  int            mode;
  int            lows;

  initial begin
    RST = 1'b1; n_WR = 1'b1; DATA_IN = '0; RD = 1'b0; rdy_clr = 1'b0;
    loop_en = 1'b0; rx_drv = 1'b1;
    m_par = 1'b0; m_frm = 1'b0; m_ovr = 1'b0; m_dout = '0;
    cyc(3);
    RST = 1'b0;
    cyc(1);

    // reset state
    chk("rst.txd", TxD, 1'b1);
    chk("rst.tx_rdy", Tx_RDY, 1'b1);
    chk("rst.tx_state", tx_state_dbg, 3'd0);
    chk("rst.rx_state", rx_state_dbg, 3'd0);
    check_state("rst");

    // 1: loopback 0x55, bit-exact TxD waveform
    loop_en = 1'b1;
    DATA_IN = 8'h55;
    n_WR = 1'b0;
    cyc(1);
    n_WR = 1'b1;
    chk("t1.tx_busy", Tx_RDY, 1'b0);
    bits1 = {1'b1, even_bit(8'h55), 8'h55, 1'b0};
    for (int i = 0; i < 11 * CPB; i++) begin
      chk($sformatf("t1.txd[%0d]", i), TxD, bits1[i / CPB]);
      cyc(1);
    end
    chk("t1.tx_rdy_back", Tx_RDY, 1'b1);
    cyc(6);
    model_push(8'h55, 1'b0, 1'b0);
    check_state("t1");
    do_rd();
    check_state("t1_rd");
    do_rd();
    check_state("t1_rd_empty");

    // 2: n_WR held low, back-to-back frames overrun a 4-deep FIFO
    DATA_IN = 8'h00;
    n_WR = 1'b0;
    prev_rdy = 1'b1;
    accepted = 0;
    budget = 0;
    while (accepted < 5 && budget < 2000) begin
      cyc(1);
      budget++;
      if (prev_rdy && !Tx_RDY) begin
        model_push(DATA_IN, 1'b0, 1'b0);
        accepted++;
        DATA_IN = DATA_IN + 8'd1;
        if (accepted == 5) n_WR = 1'b1;
      end
      prev_rdy = Tx_RDY;
    end
    n_WR = 1'b1;
    chk("t2.frames_accepted", accepted, 5);
    wait_tx_idle("t2");
    cyc(8);
    check_state("t2");
    do_clr();
    check_state("t2_clr");
    for (int i = 0; i < DEPTH; i++) begin
      do_rd();
      check_state($sformatf("t2_drain%0d", i));
    end

    // 3: wrong parity bit on 0xA3
    drive_frame(8'hA3, 1'b1, 1'b1);
    model_push(8'hA3, 1'b1, 1'b0);
    check_state("t3");
    do_rd();
    do_clr();
    check_state("t3_clr");

    // 4: 3-cycle glitch is a false start, then a clean 0x3C
    loop_en = 1'b0;
    rx_drv = 1'b0;
    cyc(3);
    rx_drv = 1'b1;
    cyc(20);
    check_state("t4_glitch");
    chk("t4.rx_idle", rx_state_dbg, 3'd0);
    drive_frame(8'h3C, 1'b0, 1'b1);
    model_push(8'h3C, 1'b0, 1'b0);
    check_state("t4");
    do_rd();

    // 5: break for 20 bit times
    rx_drv = 1'b0;
    cyc(20 * CPB);
    model_push(8'h00, 1'b0, 1'b1);
    check_state("t5");
    do_rd();
    cyc(40);
    check_state("t5_still_low");
    rx_drv = 1'b1;
    cyc(20);
    check_state("t5_released");
    do_clr();
    drive_frame(8'h5A, 1'b0, 1'b1);
    model_push(8'h5A, 1'b0, 1'b0);
    check_state("t5_next");
    do_rd();

    // randomized mix of loopback, clean, parity-error and framing-error frames
    for (int it = 0; it < 24; it++) begin
      d = 8'($urandom_range(0, 255));
      mode = $urandom_range(0, 5);
      if (mode == 0) begin
        loop_frame(d, "rnd");
      end else if (mode == 1) begin
        drive_frame(d, 1'b1, 1'b1);
        model_push(d, 1'b1, 1'b0);
      end else if (mode == 2) begin
        drive_frame(d, 1'b0, 1'b0);
        model_push(d, 1'b0, 1'b1);
      end else begin
        drive_frame(d, 1'b0, 1'b1);
        model_push(d, 1'b0, 1'b0);
      end
      check_state($sformatf("rnd%0d", it));
      repeat ($urandom_range(0, 2)) begin
        do_rd();
        check_state($sformatf("rnd%0d_rd", it));
      end
      if ($urandom_range(0, 3) == 0) begin
        do_clr();
        check_state($sformatf("rnd%0d_clr", it));
      end
    end

    // 6: reset mid-frame on both directions
    while (exp_q.size() > 0) do_rd();
    do_clr();
    drive_frame(8'h0F, 1'b1, 1'b1);
    model_push(8'h0F, 1'b1, 1'b0);
    check_state("t6_pre");
    d = 8'($urandom_range(0, 255));
    bits6 = {1'b1, even_bit(d), d, 1'b0};
    for (int c = 0; c < 44; c++) begin
      rx_drv = bits6[c / CPB];
      if (c == 8) begin
        DATA_IN = 8'($urandom_range(0, 255));
        n_WR = 1'b0;
      end
      if (c == 9 || c == 21) n_WR = 1'b1;
      if (c == 20) n_WR = 1'b0;
      cyc(1);
    end
    chk("t6.tx_busy", Tx_RDY, 1'b0);
    RST = 1'b1;
    rx_drv = 1'b1;
    cyc(1);
    exp_q.delete();
    m_par = 1'b0; m_frm = 1'b0; m_ovr = 1'b0; m_dout = '0;
    chk("t6.txd", TxD, 1'b1);
    chk("t6.tx_rdy", Tx_RDY, 1'b1);
    chk("t6.rx_state", rx_state_dbg, 3'd0);
    check_state("t6_rst");
    RST = 1'b0;
    lows = 0;
    repeat (200) begin
      cyc(1);
      if (!TxD) lows++;
    end
    chk("t6.no_extra_frame", lows, 0);
    check_state("t6_after");
    loop_frame(8'($urandom_range(0, 255)), "t6_recover");
    check_state("t6_recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/usart_fifo.md
Name: usart_fifo

Overview:
Parametrised successor to the team's fixed 8N1 usart. It is a full-duplex async serial transceiver with configurable data width, parity, stop bits and bit period, plus an RX FIFO in place of the single receive register. It sits between the CPU-side byte bus and the board pins, all on the CLK50M domain. It also adds parity/framing/overrun detection and an interrupt output.

Parameters:
CLKS_PER_BIT, 434, CLK50M cycles per bit (434 = 115200 baud); legal >= 4.
DATA_BITS, 8, data bits per frame; legal 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2 (TX sends this many; RX checks the first only).
FIFO_DEPTH, 4, RX FIFO entries; power of 2, >= 2.

Ports:
CLK50M  in  1  system clock; all logic on posedge.
RST  in  1  synchronous reset, active-high.
DATA_IN  in  DATA_BITS  TX word.
n_WR  in  1  active-low TX write strobe; sampled every cycle.
TxD  out  1  serial out, idle high.
Tx_RDY  out  1  transmitter idle and able to accept a write.
RxD  in  1  serial in, asynchronous.
Rx_RDY  out  1  RX FIFO non-empty.
DATA_OUT  out  DATA_BITS  RX FIFO head (first-word fall-through).
RD  in  1  pop RX FIFO head.
rdy_clr  in  1  clear sticky error flags.
PAR_ERR  out  1  sticky parity error.
FRM_ERR  out  1  sticky framing error.
OVR  out  1  sticky overrun.
n_INT  out  1  active-low interrupt = ~(Rx_RDY | PAR_ERR | FRM_ERR | OVR).

Behaviour:
- Reset values:
  - TxD=1, Tx_RDY=1, Rx_RDY=0, DATA_OUT=0, PAR_ERR=FRM_ERR=OVR=0, n_INT=1.
  - FIFO empty; both FSMs in IDLE.
  - RST mid-frame aborts the frame immediately; the partial RX word is discarded.
- TX FSM, states IDLE, START, DATA, PAR, STOP:
  - Write accepted on any cycle with n_WR=0 and Tx_RDY=1. DATA_IN is latched; next cycle Tx_RDY=0 and TxD=0 (START).
  - n_WR=0 while Tx_RDY=0 is ignored. n_WR held low re-triggers as soon as Tx_RDY returns high (back-to-back frames, no idle gap).
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Data is sent LSB first. PAR state is skipped when PARITY=0. Odd parity makes the total count of ones in data+parity odd; even parity makes it even.
  - STOP drives 1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE with Tx_RDY=1.
- RX FSM, states IDLE, START, DATA, PAR, STOP, WAIT_HI:
  - RxD passes through a 2-flop synchroniser; all references below are to the synchronised value.
  - IDLE: a low sample enters START. After CLKS_PER_BIT/2 cycles the line is re-sampled; if high, it is a false start and the FSM returns to IDLE with no flags set.
  - DATA/PAR/STOP: sampled every CLKS_PER_BIT cycles thereafter, at bit centres.
  - Parity mismatch sets PAR_ERR. A stop sample of 0 sets FRM_ERR.
  - At the stop sample the word is pushed to the FIFO, even if it has an error.
  - If the stop sample was 0 (break), go to WAIT_HI until RxD=1, then IDLE. Otherwise go directly to IDLE.
- RX FIFO:
  - Circular buffer with log2(FIFO_DEPTH)+1-bit read/write pointers.
  - Full when the pointers are equal except the MSB; empty when they are fully equal.
  - RD with Rx_RDY=1 pops; DATA_OUT shows the new head the next cycle. RD when empty is ignored; DATA_OUT holds its last value.
  - Push when full drops the incoming word and sets OVR; FIFO contents are unchanged.
  - Push and pop in the same cycle when full: both happen, OVR not set.
  - Push and pop in the same cycle when empty: the push occurs and the pop is ignored.
- Sticky error flags:
  - rdy_clr=1 clears all three flags next cycle.
  - If a new error event occurs in the same cycle as rdy_clr, the set wins.
- n_INT is registered, 1 cycle after its source terms.

Test Plan:
1. CLKS_PER_BIT=8, PARITY=2, TxD looped to RxD; write 0x55 -> TxD low for 8 cycles starting 1 cycle after write; bits 1,0,1,0,1,0,1,0; parity 0; stop; Rx_RDY=1, DATA_OUT=0x55, no error flags; RD -> Rx_RDY=0.
2. Loopback with n_WR held low, DATA_IN incremented on each Tx_RDY rise, RD never asserted, FIFO_DEPTH=4 -> words 0x00..0x03 in the FIFO, the 5th frame sets OVR, DATA_OUT stays 0x00; rdy_clr -> OVR=0 while Rx_RDY stays 1.
3. Drive RxD with even-parity frame 0xA3 carrying a wrong parity bit -> PAR_ERR=1, word 0xA3 pushed, n_INT=0.
4. Drive RxD low for 3 cycles then high (CLKS_PER_BIT=8) -> no push, no flags, RX back in IDLE; the next valid frame 0x3C is received correctly.
5. Hold RxD low for 20 bit times -> word 0x00 pushed, FRM_ERR=1, no further pushes until RxD rises and a new start bit arrives.
6. Assert RST during TX data bit 3 and RX data bit 4 -> next cycle TxD=1, Tx_RDY=1, FIFO empty, all flags 0; write during the busy period before reset produced no extra frame.
